// File: rtl/reaction_sequencer_if.sv
// Front-panel bundle of the reaction-time sequencer.
// master is the sequencer; slave is the panel or bench side.
interface reaction_sequencer_if #(
  parameter int SCORE_W = 13
);
  logic               buttonStart;
  logic               buttonHit;
  logic               ledRed;
  logic               ledGreen;
  logic [SCORE_W-1:0] displayScore;
  logic [1:0]         displaySel;
  logic [SCORE_W-1:0] bestScore;
  logic               bestValid;
  logic               roundDone;

  modport master (
    input  buttonStart, buttonHit,
    output ledRed, ledGreen, displayScore, displaySel,
    output bestScore, bestValid, roundDone
  );

  modport slave (
    output buttonStart, buttonHit,
    input  ledRed, ledGreen, displayScore, displaySel,
    input  bestScore, bestValid, roundDone
  );
endinterface

// File: rtl/reaction_sequencer.sv
// Reaction-time game sequencer: IDLE/ARM/GO/DONE/FOUL round flow.
// Optional HOLD_RESULT_EN: timed auto-return to IDLE from DONE/FOUL.
module reaction_sequencer #(
  parameter int TICK_DIV        = 50000,
  parameter int DELAY_MIN_MS    = 1000,
  parameter int DELAY_SPAN_LOG2 = 11,
  parameter int SCORE_W         = 13
) (
  input  logic                clk,
  input  logic                reset,
  reaction_sequencer_if.master bus
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ARM  = 3'd1;
  localparam logic [2:0] GO   = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] FOUL = 3'd4;

  localparam int PW      = $clog2(TICK_DIV);
  localparam int DLY_MAX = DELAY_MIN_MS + (1 << DELAY_SPAN_LOG2) - 1;
  localparam int DW      = (DLY_MAX < 2) ? 1 : $clog2(DLY_MAX + 1);

  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0] SPAN_MASK =
    16'((32'd1 << DELAY_SPAN_LOG2) - 32'd1);
  localparam logic [SCORE_W-1:0] S_MAX = '1;
  localparam logic [SCORE_W-1:0] S_PRE =
    {{(SCORE_W-1){1'b1}}, 1'b0};

  logic [2:0]         state;
  logic               start_prev;
  logic               hit_prev;
  logic [15:0]        lfsr;
  logic [PW-1:0]      presc;
  logic [DW-1:0]      delay;
  logic [SCORE_W-1:0] cnt;
  logic [SCORE_W-1:0] last;
  logic [SCORE_W-1:0] best;
  logic               best_valid;
  logic               done_pulse;

  logic               start_rise;
  logic               hit_rise;
  logic               tick;
  logic               fb;
  logic               to_arm;
  logic               to_go;
  logic               to_done;
  logic               to_foul;
  logic               to_idle;
  logic               presc_clr;
  logic [SCORE_W-1:0] score_in;
  logic [1:0]         sel;
  logic               alt_phase;

  assign start_rise = bus.buttonStart & ~start_prev;
  assign hit_rise   = bus.buttonHit & ~hit_prev;
  assign tick       = (presc == P_LAST);
  assign fb         = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

`ifdef HOLD_RESULT_EN
  logic [10:0] hold_cnt;
  logic [8:0]  alt_cnt;
  logic        alt;
  logic        in_result;

  assign in_result = (state == DONE) || (state == FOUL);
  assign to_idle   = in_result && !start_rise && tick
                     && (hold_cnt == 11'd1999);
  assign presc_clr = to_arm || to_go || to_done || to_foul || tick;
  assign alt_phase = alt;

  always_ff @(posedge clk) begin
    if (reset || to_done || to_foul) begin
      hold_cnt <= '0;
      alt_cnt  <= '0;
      alt      <= 1'b0;
    end else if (in_result && tick) begin
      hold_cnt <= hold_cnt + 1'b1;
      if (alt_cnt == 9'd499) begin
        alt_cnt <= '0;
        alt     <= ~alt;
      end else begin
        alt_cnt <= alt_cnt + 1'b1;
      end
    end
  end
`else
  assign to_idle   = 1'b0;
  assign presc_clr = to_arm || to_go || tick;
  assign alt_phase = 1'b0;
`endif

  always_comb begin
    to_arm   = 1'b0;
    to_go    = 1'b0;
    to_done  = 1'b0;
    to_foul  = 1'b0;
    score_in = cnt;
    case (state)
      IDLE: to_arm = start_rise;
      ARM: begin
        // a hit on the final tick still counts as a foul
        if (hit_rise)
          to_foul = 1'b1;
        else if (tick && delay <= DW'(1))
          to_go = 1'b1;
      end
      GO: begin
        if (hit_rise) begin
          to_done = 1'b1;
        end else if (tick && cnt == S_PRE) begin
          to_done  = 1'b1;
          score_in = S_MAX;
        end
      end
      DONE, FOUL: to_arm = start_rise;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      start_prev <= 1'b1;
      hit_prev   <= 1'b1;
      lfsr       <= 16'hACE1;
      presc      <= '0;
      delay      <= '0;
      cnt        <= '0;
      last       <= '0;
      best       <= '0;
      best_valid <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      start_prev <= bus.buttonStart;
      hit_prev   <= bus.buttonHit;
      lfsr       <= {lfsr[14:0], fb};
      presc      <= presc_clr ? '0 : presc + 1'b1;
      done_pulse <= to_done || to_foul;
      if (to_arm) begin
        state <= ARM;
        delay <= DW'(32'(DELAY_MIN_MS) + 32'(lfsr & SPAN_MASK));
      end else if (to_go) begin
        state <= GO;
        cnt   <= '0;
      end else if (to_done) begin
        state <= DONE;
        cnt   <= score_in;
        last  <= score_in;
        if (!best_valid || score_in < best) begin
          best       <= score_in;
          best_valid <= 1'b1;
        end
      end else if (to_foul) begin
        state <= FOUL;
      end else if (to_idle) begin
        state <= IDLE;
      end else begin
        if (state == ARM && tick)
          delay <= delay - 1'b1;
        if (state == GO && tick)
          cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    sel = 2'b00;
    case (state)
      IDLE: sel = best_valid ? 2'b10 : 2'b00;
      DONE: sel = (best_valid && alt_phase) ? 2'b10 : 2'b01;
      FOUL: sel = 2'b11;
      default: sel = 2'b00;
    endcase
  end

  always_comb begin
    bus.displayScore = '0;
    unique case (1'b1)
      sel == 2'b01: bus.displayScore = last;
      sel == 2'b10: bus.displayScore = best;
      default:      bus.displayScore = '0;
    endcase
  end

  assign bus.ledRed     = (state == ARM) || (state == FOUL);
  assign bus.ledGreen   = (state == GO);
  assign bus.displaySel = sel;
  assign bus.bestScore  = best;
  assign bus.bestValid  = best_valid;
  assign bus.roundDone  = done_pulse;
endmodule

// File: tb/tb_reaction_sequencer.sv
// Bench for reaction_sequencer: elapsed-time model compared every
// cycle, plus directed rounds with hand-computed results.
module tb_reaction_sequencer;
  localparam int TD   = 4;
  localparam int DMIN = 3;
  localparam int SMAX = 15;

  localparam int P_IDLE = 0;
  localparam int P_ARM  = 1;
  localparam int P_GO   = 2;
  localparam int P_DONE = 3;
  localparam int P_FOUL = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  reaction_sequencer_if #(.SCORE_W(4)) bus ();

  reaction_sequencer #(
    .TICK_DIV(TD),
    .DELAY_MIN_MS(DMIN),
    .DELAY_SPAN_LOG2(0),
    .SCORE_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(string name, int act, int exp);
    total_cnt++;
    if (act == exp)
      pass_cnt++;
    else
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h",
               name, $time, act, exp);
  endtask

  // Model: phase plus cycles spent in it; ticks fall every TD cycles.
  int m_ph = P_IDLE;
  int m_n = 1;
  int m_last = 0;
  int m_best = 0;
  bit m_bv = 1'b0;
  bit m_pulse = 1'b0;
  bit m_sp = 1'b1;
  bit m_hp = 1'b1;
  bit m_ok = 1'b0;

  always @(posedge clk) begin
    bit rs;
    bit rh;
    int nxt;
    int sc;
    if (reset) begin
      m_ph = P_IDLE; m_n = 1; m_last = 0; m_best = 0;
      m_bv = 0; m_pulse = 0; m_sp = 1; m_hp = 1; m_ok = 1;
    end else if (m_ok) begin
      rs = bus.buttonStart && !m_sp;
      rh = bus.buttonHit && !m_hp;
      m_sp = bus.buttonStart;
      m_hp = bus.buttonHit;
      m_pulse = 0;
      nxt = m_ph;
      sc = 0;
      case (m_ph)
        P_IDLE: if (rs) nxt = P_ARM;
        P_ARM: begin
          if (rh) nxt = P_FOUL;
          else if (m_n == DMIN * TD) nxt = P_GO;
        end
        P_GO: begin
          if (rh) begin
            nxt = P_DONE; sc = (m_n - 1) / TD;
          end else if (m_n % TD == 0 && m_n / TD == SMAX) begin
            nxt = P_DONE; sc = SMAX;
          end
        end
        default: if (rs) nxt = P_ARM;
      endcase
      if (nxt != m_ph) begin
        m_n = 1;
        m_pulse = (nxt == P_DONE) || (nxt == P_FOUL);
        if (nxt == P_DONE) begin
          m_last = sc;
          if (!m_bv || sc < m_best) begin
            m_best = sc; m_bv = 1;
          end
        end
      end else begin
        m_n++;
      end
      m_ph = nxt;
    end
  end

  always @(negedge clk) begin
    int e_sel;
    int e_disp;
    int act;
    int exp;
    if (m_ok) begin
      case (m_ph)
        P_IDLE:  e_sel = m_bv ? 2 : 0;
        P_DONE:  e_sel = 1;
        P_FOUL:  e_sel = 3;
        default: e_sel = 0;
      endcase
      e_disp = (e_sel == 1) ? m_last : (e_sel == 2) ? m_best : 0;
      exp = {(m_ph == P_ARM || m_ph == P_FOUL), (m_ph == P_GO),
             2'(e_sel), 4'(e_disp), 4'(m_best), m_bv, m_pulse};
      act = {bus.ledRed, bus.ledGreen, bus.displaySel,
             bus.displayScore, bus.bestScore, bus.bestValid,
             bus.roundDone};
      check("model{red,grn,sel,disp,best,bv,done}", act, exp);
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_round();
    bus.buttonStart = 1'b1;
    step(1);
    bus.buttonStart = 1'b0;
  endtask

  task automatic wait_go();
    int k = 0;
    while (!bus.ledGreen && k < 200) begin
      step(1);
      k++;
    end
    check("reach_go", int'(bus.ledGreen), 1);
  endtask

  task automatic go_hit(int k);
    step(k - 1);
    bus.buttonHit = 1'b1;
    step(1);
    bus.buttonHit = 1'b0;
  endtask

  initial begin
    int n;
    bus.buttonStart = 1'b1;
    bus.buttonHit = 1'b0;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(3);
    check("t1_led_red", int'(bus.ledRed), 0);
    check("t1_sel", int'(bus.displaySel), 0);
    check("t1_best_valid", int'(bus.bestValid), 0);

    bus.buttonStart = 1'b0;
    step(1);
    start_round();
    n = 0;
    while (bus.ledRed && n < 100) begin
      n++;
      step(1);
    end
    check("t2_arm_cycles", n, 12);
    check("t2_green", int'(bus.ledGreen), 1);
    go_hit(20);
    check("t2_score", int'(bus.displayScore), 4);
    check("t2_best", int'(bus.bestScore), 4);
    check("t2_best_valid", int'(bus.bestValid), 1);
    n = 0;
    repeat (4) begin
      if (bus.roundDone) n++;
      step(1);
    end
    check("t2_done_pulses", n, 1);

    start_round();
    wait_go();
    go_hit(30);
    check("t3_score7", int'(bus.displayScore), 7);
    check("t3_best4", int'(bus.bestScore), 4);
    start_round();
    wait_go();
    go_hit(10);
    check("t3_score2", int'(bus.displayScore), 2);
    check("t3_best2", int'(bus.bestScore), 2);

    start_round();
    step(5);
    bus.buttonHit = 1'b1;
    step(1);
    bus.buttonHit = 1'b0;
    check("t4_red", int'(bus.ledRed), 1);
    check("t4_sel", int'(bus.displaySel), 3);
    check("t4_disp", int'(bus.displayScore), 0);
    check("t4_best", int'(bus.bestScore), 2);
    check("t4_done", int'(bus.roundDone), 1);
    start_round();
    check("t4_rearm_red", int'(bus.ledRed), 1);
    check("t4_rearm_sel", int'(bus.displaySel), 0);

    wait_go();
    n = 0;
    while (bus.ledGreen && n < 200) begin
      n++;
      step(1);
    end
    check("t5_timeout_cycles", n, 60);
    check("t5_timeout_score", int'(bus.displayScore), 15);
    check("t5_sel", int'(bus.displaySel), 1);
    check("t5_best", int'(bus.bestScore), 2);
    start_round();
    wait_go();
    go_hit(40);
    check("t5_tick_hit_score", int'(bus.displayScore), 9);

    start_round();
    wait_go();
    step(5);
    reset = 1'b1;
    step(1);
    check("t6_green", int'(bus.ledGreen), 0);
    check("t6_best_valid", int'(bus.bestValid), 0);
    check("t6_best", int'(bus.bestScore), 0);
    check("t6_lfsr", int'(dut.lfsr), 'hACE1);
    reset = 1'b0;
    step(3);
    check("t6_idle_sel", int'(bus.displaySel), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/reaction_sequencer.md
Name: reaction_sequencer

Overview:
Top-level sequencer for the reaction-time game. It drives the round flow: idle, armed with a random delay under the red LED, go under the green LED while the reaction is timed, then result or foul. It owns the millisecond tick, the reaction counter, the random-delay LFSR, the best-score register and the display-source select. The front-panel decode consumes its outputs.

Parameters:
TICK_DIV, 50000, clk cycles per reaction tick (1 ms at 50 MHz); must be >= 2.
DELAY_MIN_MS, 1000, fixed part of the armed delay, in ticks.
DELAY_SPAN_LOG2, 11, random part of the delay is LFSR[DELAY_SPAN_LOG2-1:0]; 0 means a fixed delay.
SCORE_W, 13, width of the reaction counter and score outputs.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
buttonStart  input  1  debounced level, start/restart button
buttonHit  input  1  debounced level, reaction button
ledRed  output  1  high in ARM and FOUL
ledGreen  output  1  high in GO
displayScore  output  SCORE_W  value routed to the display
displaySel  output  2  display source: 00 blank, 01 last score, 10 best score, 11 foul
bestScore  output  SCORE_W  lowest valid score since reset
bestValid  output  1  bestScore holds a real score
roundDone  output  1  one-cycle pulse on entry to DONE or FOUL

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset behaviour:
  - state=IDLE; all outputs 0; LFSR=16'hACE1.
  - Prescaler, reaction counter and last score cleared.
  - Edge-detect registers for both buttons are reset to 1, so a button held through reset does not trigger.
- Edge detection: rise = level & ~prev; prev is registered every cycle.
- Output timing: all outputs except bestScore, bestValid and displayScore are decoded from the state register. They change the cycle after the triggering edge is sampled.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clk cycle in every state except reset.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick=1 when it equals TICK_DIV-1.
  - Cleared on every entry to ARM and to GO.
- IDLE:
  - displaySel=10 if bestValid, else 00.
  - Start rise -> ARM; hit is ignored.
- ARM:
  - On entry, delay counter loads DELAY_MIN_MS + LFSR[DELAY_SPAN_LOG2-1:0]; the LFSR value is the one present in the entry cycle.
  - Counter decrements on tick. The tick that brings it to 0 -> GO.
  - Hit rise -> FOUL. A hit rise wins over a same-cycle final tick.
  - Start is ignored.
- GO:
  - Reaction counter cleared on entry; increments on tick.
  - Hit rise -> DONE, lastScore = counter value before any same-cycle increment.
  - If the counter reaches 2^SCORE_W-1 -> DONE with lastScore = 2^SCORE_W-1 (timeout); the counter saturates and never wraps.
  - Start is ignored.
- DONE:
  - displaySel=01, displayScore=lastScore.
  - On the entry cycle, if !bestValid or lastScore<bestScore, then bestScore=lastScore and bestValid=1. Timeout scores do update best.
  - Start rise -> ARM (new round).
- FOUL:
  - displaySel=11, displayScore=0.
  - bestScore is unchanged.
  - Start rise -> ARM.
- Display in other states: displayScore=bestScore when displaySel=10, otherwise 0.
- Reset mid-round returns to IDLE next edge and clears best.
- Simultaneous start and hit rise: each state reacts only to the button it listens to.

Optional Feature:
Macro HOLD_RESULT_EN.
- Defined: DONE and FOUL return to IDLE automatically after 2000 ticks unless start rises first. While the return is pending, displaySel alternates 01/10 every 500 ticks in DONE when bestValid.
- Undefined: DONE and FOUL hold until start rises, and displaySel stays static.

Test Plan:
Bench parameters: TICK_DIV=4, DELAY_MIN_MS=3, DELAY_SPAN_LOG2=0, SCORE_W=4, macro undefined.
1. Reset held with buttonStart=1, then released, start held -> stays IDLE, displaySel=00, bestValid=0.
2. Start rise -> ledRed=1 for exactly 12 cycles, then ledGreen=1. Hit rise at the 5th tick of GO -> DONE, displayScore=4, bestScore=4, bestValid=1, roundDone pulses once.
3. From DONE, start, then hit after 7 ticks of GO -> lastScore=7, bestScore stays 4. Next round with hit after 2 ticks -> bestScore=2.
4. Hit rise during ARM cycle 6 -> FOUL, ledRed=1, displaySel=11, displayScore=0, bestScore unchanged. Start -> ARM.
5. No hit in GO -> DONE after 15 ticks with displayScore=15, counter not wrapped. Hit rise coincident with a tick at counter=9 -> score 9.
6. Assert reset during GO -> IDLE next cycle, ledGreen=0, bestValid=0, LFSR=16'hACE1.
